serial_byte_loader: RTL and testbench
=====================================

# serial_byte_loader

Serial-to-parallel front end that assembles one byte from a bit-serial input stream, optionally checks a trailing parity bit, and issues a one-cycle load strobe. It sits directly upstream of the 8-bit holding register. `d` drives the register's eight data inputs (`d[7]`→bit 7 … `d[0]`→bit 0), and `ld` drives its load enable. The register captures the byte on the clock edge that ends the `ld` cycle.

## Interface
- `PARITY_EN`, default 1: when 1, a ninth serial bit (parity) follows the 8 data bits and is checked.
- `PARITY_ODD`, default 0: when 0, even parity (XOR of 8 data bits and parity bit = 0); when 1, odd parity (XOR = 1).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled only in IDLE and LOAD.
- `ser_in`  in  1  serial data bit, MSB first.
- `ser_valid`  in  1  `ser_in` is accepted on this edge (DATA/PAR states only).
- `d`  out  8  assembled byte.
- `ld`  out  1  one-cycle load strobe to the holding register.
- `busy`  out  1  high in DATA and PAR.
- `par_err`  out  1  one-cycle pulse on parity mismatch.

## Operation
- States: IDLE, DATA, PAR, LOAD, ERR.
- IDLE: `start`=1 moves to DATA; the bit count is cleared. `ser_valid` is ignored.
- DATA: each edge with `ser_valid`=1 does `d <= {d[6:0], ser_in}`, increments the 3-bit count and folds `ser_in` into the running parity. Cycles with `ser_valid`=0 change nothing.
  - On the 8th accepted bit (count 7→0 wrap): go to PAR if `PARITY_EN`=1, else go to LOAD.
- PAR: the edge with `ser_valid`=1 compares parity.
  - Match: go to LOAD.
  - Mismatch: go to ERR.
  - `d` is not shifted in this state.
- LOAD: `ld`=1 for exactly this cycle; `d` is stable throughout.
  - `start`=1 in this cycle goes to DATA, giving back-to-back frames with no IDLE gap.
  - Otherwise go to IDLE.
- ERR: `par_err`=1 for exactly this cycle; `ld` stays 0. Always goes to IDLE.
- `start` in DATA, PAR or ERR is ignored; it neither restarts nor aborts the frame.
- `d` holds its value from the end of a frame until the first shift of the next frame, including after a parity error.
- All outputs are Moore-decoded from state or register; there is no combinational input-to-output path.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `d`=8'h00, count=0, parity accumulator=0, `ld`=0, `busy`=0, `par_err`=0. The release is synchronised externally.
- Reset mid-frame aborts immediately. No `ld` or `par_err` is produced for the aborted frame.
- `start` high at edge 0 → DATA from edge 0. With `ser_valid` held high, bits are taken at edges 1–8.
  - `PARITY_EN`=1: parity bit at edge 9, `ld` (or `par_err`) high during the cycle after edge 9; the holding register captures at edge 10.
  - `PARITY_EN`=0: `ld` high during the cycle after edge 8.
- Latency from the last accepted bit to the `ld` cycle is exactly 1 cycle. Gaps in `ser_valid` stretch a frame cycle-for-cycle.
- `busy` is high from the cycle after `start` is accepted through the cycle of the last accepted bit.

## Structure
- A shared package holds: the state encoding (3-bit localparams IDLE/DATA/PAR/LOAD/ERR), `BYTE_W`=8 and `CNT_W`=3.
- One sub-module, `bit_counter_3`: a 3-bit counter with enable and synchronous clear, asynchronous active-low reset, and a `wrap` output asserted when count=7 and enable=1.
- The shift register, parity accumulator and FSM stay in the top module.

## Test plan
- `PARITY_EN`=1, even parity: send 0xA5 MSB-first (1,0,1,0,0,1,0,1) then parity 0, `ser_valid` continuous → `ld`=1 for one cycle, `d`=8'hA5, `par_err`=0.
- Same frame with parity bit 1 → `par_err`=1 for one cycle, `ld` never asserted, `d`=8'hA5, FSM back in IDLE.
- 0x3C with `ser_valid` low for 2 cycles between bits 3 and 4 → `busy` stays high through the gap, `ld` is 2 cycles later than the no-gap case, `d`=8'h3C.
- `rst` pulled low after 4 bits of 0xF0 → `d`=0x00, `busy`=0 immediately. A new 0x81 frame then yields `d`=8'h81 with no residue.
- `start` held high during the LOAD cycle of 0x12, followed by 0x34 → two `ld` pulses with `d`=8'h12 then 8'h34, and no IDLE cycle between frames.
- `PARITY_EN`=0: send 0x7E → `ld` in the cycle after the 8th bit, `d`=8'h7E, `par_err` never asserted.

Source files
------------

// File: rtl/serial_byte_loader_pkg.sv
// Shared definitions for the serial byte loader: FSM state encoding and
// the data/counter widths used by the top level and the bit counter.
package serial_byte_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_PAR  = 3'd2,
    S_LOAD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/bit_counter_3.sv
// 3-bit bit counter for the serial byte loader.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   en    - count one accepted bit
//   clr   - synchronous clear (has priority over en)
//   count - current count
//   wrap  - high when count is 7 and en is high (the 8th bit of a byte)
module bit_counter_3
  import serial_byte_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign wrap = en && (count == '1);

endmodule

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel front end: shifts in 8 bits MSB first, optionally
// checks a trailing parity bit, then strobes ld for one cycle so the
// downstream holding register captures d.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   start     - frame request, honoured only in IDLE and LOAD
//   ser_in    - serial data bit
//   ser_valid - ser_in is accepted on this edge (DATA/PAR only)
//   d         - assembled byte, held between frames
//   ld        - one-cycle load strobe
//   busy      - frame in progress (DATA or PAR)
//   par_err   - one-cycle parity mismatch pulse
module serial_byte_loader
  import serial_byte_loader_pkg::*;
#(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic [BYTE_W-1:0] d,
  output logic              ld,
  output logic              busy,
  output logic              par_err
);

  state_t           state;
  state_t           state_nxt;
  logic             shift_en;
  logic             start_ok;
  logic             cnt_wrap;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_acc;
  logic             par_ok;

  assign shift_en = (state == S_DATA) && ser_valid;
  assign start_ok = ((state == S_IDLE) || (state == S_LOAD)) && start;
  // XOR of the data bits and the parity bit must equal the selected sense.
  assign par_ok   = ((par_acc ^ ser_in) == PARITY_ODD);

  bit_counter_3 u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (shift_en),
    .clr   (start_ok),
    .count (bit_cnt),
    .wrap  (cnt_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // d is deliberately not cleared on start: it must hold the previous
  // byte until the first shift of the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d       <= '0;
      par_acc <= 1'b0;
    end else if (start_ok) begin
      par_acc <= 1'b0;
    end else if (shift_en) begin
      d       <= {d[BYTE_W-2:0], ser_in};
      par_acc <= par_acc ^ ser_in;
    end
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    busy      = 1'b0;
    par_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (cnt_wrap) state_nxt = PARITY_EN ? S_PAR : S_LOAD;
      end
      S_PAR: begin
        busy = 1'b1;
        if (ser_valid) state_nxt = par_ok ? S_LOAD : S_ERR;
      end
      S_LOAD: begin
        ld        = 1'b1;
        state_nxt = start ? S_DATA : S_IDLE;
      end
      S_ERR: begin
        par_err   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  a_wrap_at_seven: assert property (@(posedge clk) disable iff (!rst)
    cnt_wrap |-> (bit_cnt == '1));

endmodule

// File: tb/tb_serial_byte_loader.sv
module tb_serial_byte_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ser_in;
  logic       ser_valid;
  logic [7:0] d_p;
  logic [7:0] d_n;
  logic       ld_p, ld_n, busy_p, busy_n, err_p, err_n;

  int total = 0;
  int bad   = 0;
  int np_err_seen = 0;

  always #5 clk = ~clk;

  serial_byte_loader #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .ser_valid(ser_valid),
    .d(d_p), .ld(ld_p), .busy(busy_p), .par_err(err_p)
  );

  serial_byte_loader #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_np (
    .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .ser_valid(ser_valid),
    .d(d_n), .ld(ld_n), .busy(busy_n), .par_err(err_n)
  );

  always @(negedge clk) if (err_n === 1'b1) np_err_seen++;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    bit         np;
    int         gap_at;
    int         gap_len;
    int         exp_ld;
    int         exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_ld(input bit np);
    return np ? ld_n : ld_p;
  endfunction
  function automatic logic cur_err(input bit np);
    return np ? err_n : err_p;
  endfunction
  function automatic logic cur_busy(input bit np);
    return np ? busy_n : busy_p;
  endfunction
  function automatic logic [7:0] cur_d(input bit np);
    return np ? d_n : d_p;
  endfunction

  task automatic send_bits(input logic [7:0] data, input logic pbit);
    for (int i = 7; i >= 0; i--) begin
      ser_valid = 1'b1;
      ser_in    = data[i];
      tick();
    end
    ser_valid = 1'b1;
    ser_in    = pbit;
    tick();
    ser_valid = 1'b0;
  endtask

  // Edge 0 is the start edge; first_edge is the edge after which ld/par_err
  // is first seen high.
  task automatic run_frame(input logic [7:0] data, input logic pbit, input bit np,
                           input int gap_at, input int gap_len,
                           output int ld_cnt, output int err_cnt, output int first_edge,
                           output logic [7:0] d_cap, output int busy_bad);
    int edge_n = 0;
    ld_cnt = 0; err_cnt = 0; first_edge = -1; d_cap = '0; busy_bad = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (7 - i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          ser_valid = 1'b0;
          start     = 1'b1;
          tick();
          edge_n++;
          start = 1'b0;
          if (cur_busy(np) !== 1'b1) busy_bad++;
        end
      end
      ser_valid = 1'b1;
      ser_in    = data[i];
      tick();
      edge_n++;
      ser_valid = 1'b0;
      if (!(np && i == 0) && cur_busy(np) !== 1'b1) busy_bad++;
    end
    if (!np) begin
      ser_valid = 1'b1;
      ser_in    = pbit;
      tick();
      edge_n++;
      ser_valid = 1'b0;
    end
    for (int j = 0; j < 3; j++) begin
      if (cur_ld(np) === 1'b1) begin
        ld_cnt++;
        if (first_edge < 0) begin first_edge = edge_n; d_cap = cur_d(np); end
      end
      if (cur_err(np) === 1'b1) begin
        err_cnt++;
        if (first_edge < 0) begin first_edge = edge_n; d_cap = cur_d(np); end
      end
      if (j == 0 && cur_busy(np) !== 1'b0) busy_bad++;
      tick();
      edge_n++;
    end
  endtask

  initial begin
    int ld_cnt, err_cnt, first_edge, busy_bad;
    logic [7:0] d_cap;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, -1, 0, 1, 0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, -1, 0, 0, 1};
    vecs[2] = '{8'h00, 1'b0, 1'b0, -1, 0, 1, 0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, -1, 0, 1, 0};
    vecs[4] = '{8'h01, 1'b1, 1'b0, -1, 0, 1, 0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, -1, 0, 0, 1};
    vecs[6] = '{8'h3C, 1'b1, 1'b0, -1, 0, 0, 1};
    vecs[7] = '{8'h3C, 1'b0, 1'b0,  3, 2, 1, 0};
    vecs[8] = '{8'h7E, 1'b0, 1'b1, -1, 0, 1, 0};

    rst = 1'b0; start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
    #12;
    check("reset_d", int'(d_p), 8'h00);
    check("reset_ld", int'(ld_p), 0);
    check("reset_busy", int'(busy_p), 0);
    check("reset_par_err", int'(err_p), 0);
    check("reset_np_d", int'(d_n), 8'h00);
    check("reset_np_ld", int'(ld_n), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Mid-frame reset: four 1-bits of 0xF0, then asynchronous reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1;
      ser_in    = 1'b1;
      tick();
    end
    ser_valid = 1'b0;
    check("midframe_d_before", int'(d_p), 8'h0F);
    check("midframe_busy_before", int'(busy_p), 1);
    #2 rst = 1'b0;
    #1;
    check("abort_d", int'(d_p), 8'h00);
    check("abort_busy", int'(busy_p), 0);
    check("abort_np_busy", int'(busy_n), 0);
    tick();
    check("abort_ld", int'(ld_p), 0);
    check("abort_par_err", int'(err_p), 0);
    rst = 1'b1;
    tick();
    run_frame(8'h81, 1'b0, 1'b0, -1, 0, ld_cnt, err_cnt, first_edge, d_cap, busy_bad);
    check("after_abort_ld_cnt", ld_cnt, 1);
    check("after_abort_err_cnt", err_cnt, 0);
    check("after_abort_ld_edge", first_edge, 9);
    check("after_abort_d", int'(d_cap), 8'h81);

    // Back-to-back frames: start held in the LOAD cycle of 0x12.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(8'h12, 1'b0);
    check("b2b_first_ld", int'(ld_p), 1);
    check("b2b_first_d", int'(d_p), 8'h12);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_no_idle_busy", int'(busy_p), 1);
    check("b2b_gap_ld", int'(ld_p), 0);
    send_bits(8'h34, 1'b1);
    check("b2b_second_ld", int'(ld_p), 1);
    check("b2b_second_d", int'(d_p), 8'h34);
    check("b2b_second_err", int'(err_p), 0);
    tick();
    check("b2b_ld_single", int'(ld_p), 0);
    check("b2b_idle_busy", int'(busy_p), 0);
    tick();

    for (int v = 0; v < 9; v++) begin
      int exp_edge;
      exp_edge = (vecs[v].np ? 8 : 9) + vecs[v].gap_len;
      run_frame(vecs[v].data, vecs[v].pbit, vecs[v].np, vecs[v].gap_at, vecs[v].gap_len,
                ld_cnt, err_cnt, first_edge, d_cap, busy_bad);
      check($sformatf("vec%0d_ld_cnt", v), ld_cnt, vecs[v].exp_ld);
      check($sformatf("vec%0d_err_cnt", v), err_cnt, vecs[v].exp_err);
      check($sformatf("vec%0d_edge", v), first_edge, exp_edge);
      check($sformatf("vec%0d_d", v), int'(d_cap), int'(vecs[v].data));
      check($sformatf("vec%0d_busy", v), busy_bad, 0);
      check($sformatf("vec%0d_d_hold", v), int'(cur_d(vecs[v].np)), int'(vecs[v].data));
    end

    check("np_par_err_never", np_err_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
